uart_button_pio: RTL and testbench
==================================

UART_BUTTON_PIO -- requirements
Module: uart_button_pio

Interface
REQ-001 Parameter WIDTH, default 4, is the number of input pins (1..32).
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, is the stable cycles required before a pin change is accepted (>=2).
REQ-003 Parameter EDGE_TYPE, default 0, selects capture edge: 0 rising, 1 falling, 2 any.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 address  input  2  Avalon-MM slave word address.
REQ-008 chipselect  input  1  slave select.
REQ-009 write_n  input  1  active-low write strobe.
REQ-010 writedata  input  32  write data.
REQ-011 readdata  output  32  registered read data.
REQ-012 in_port  input  WIDTH  asynchronous external pins (buttons/switches).
REQ-013 irq  output  1  level interrupt request, active-high.

Function
REQ-014 Each in_port bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Per bit, a debounce counter SHALL increment each cycle while the synchronized value differs from the debounced value, and SHALL clear to 0 whenever they are equal.
REQ-016 When a counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced bit SHALL take the synchronized value on that edge and the counter SHALL clear.
REQ-017 Counter width SHALL be clog2(DEBOUNCE_CYCLES); the counter SHALL never wrap.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL NOT change the debounced bit.
REQ-019 Edge detection SHALL compare the debounced bit with its one-cycle-delayed copy, per EDGE_TYPE.
REQ-020 A detected edge SHALL set the matching edge_capture bit one cycle after the debounced bit changes; the bit stays set until cleared.
REQ-021 Register map: addr 0 data (RO, debounced value); addr 1 reads 0, writes ignored; addr 2 irqmask (RW, WIDTH bits); addr 3 edge_capture (read; write-1-to-clear per bit).
REQ-022 A write SHALL occur when chipselect=1 and write_n=0; it takes effect on that clock edge.
REQ-023 If an edge sets and a write-1 clears the same edge_capture bit in the same cycle, set SHALL win.
REQ-024 readdata SHALL be registered: it shows the addressed register, zero-extended to 32 bits, one cycle after the address is presented (read latency 1).
REQ-025 readdata SHALL update every cycle from address, regardless of chipselect.
REQ-026 irq SHALL be the OR-reduction of (edge_capture AND irqmask), driven combinationally from registers with no added latency.
REQ-027 Writes to addr 0 SHALL be ignored.
REQ-028 Unused upper bits of writedata SHALL be ignored; unused upper bits of readdata SHALL read 0.

Reset
REQ-029 While reset=1 at a clock edge, the following SHALL clear to 0: synchronizer flops, debounce counters, debounced value, its delayed copy, irqmask, edge_capture and readdata; irq therefore reads 0.
REQ-030 Reset asserted mid-debounce SHALL discard the partial count; no edge is captured from the reset transition itself.
REQ-031 After reset deasserts, a pin held at 1 SHALL be accepted after the synchronizer delay plus DEBOUNCE_CYCLES cycles; with EDGE_TYPE 0 this sets edge_capture.

Verification (DEBOUNCE_CYCLES=4, WIDTH=4, EDGE_TYPE=0)
REQ-032 in_port 0000->0001 held for 10 cycles -> data reads 0x1; edge_capture reads 0x1; irq stays 0 (mask 0).
REQ-033 Write irqmask=0x1, then press bit 0 -> irq=1; write 0x1 to addr 3 -> edge_capture=0, irq=0 the next cycle.
REQ-034 Pulse bit 2 high for 3 cycles, then low -> data stays 0x0; edge_capture stays 0x0.
REQ-035 Edge on bit 1 coincides with a write of 0x2 to addr 3 -> edge_capture bit 1 remains 1.
REQ-036 Press bit 3 and assert reset at debounce count 2 -> all registers read 0; after release of reset with the pin held at 1, bit 3 is accepted 4 cycles after the synchronizer output.
REQ-037 Read addr 1 -> 0x00000000; write 0xFFFFFFFF to addr 2 -> reading addr 2 returns 0x0000000F with 1-cycle latency.

Source files
------------

// File: rtl/uart_button_pio.sv
// uart_button_pio: debounced Avalon-MM PIO input port with edge capture and level interrupt
module uart_button_pio #(
  parameter int WIDTH = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] sync1_q, sync2_q, deb_q, deb_d, dly_q, mask_q, mask_d, cap_q, cap_d, edg, clr;
  logic [CW-1:0] cnt_q [WIDTH];
  logic [CW-1:0] cnt_d [WIDTH];
  logic [31:0] readdata_d;
  logic wr;
  logic unused_ok;
  assign unused_ok = &{1'b0, writedata};
  assign irq = |(cap_q & mask_q);
  always_comb begin
    wr = chipselect & ~write_n;
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = (sync2_q[i] != deb_q[i] && cnt_q[i] != CNT_MAX) ? cnt_q[i] + 1'b1 : '0;
      deb_d[i] = (sync2_q[i] != deb_q[i] && cnt_q[i] == CNT_MAX) ? sync2_q[i] : deb_q[i];
    end
    edg = EDGE_TYPE == 0 ? deb_q & ~dly_q : EDGE_TYPE == 1 ? ~deb_q & dly_q : deb_q ^ dly_q;
    clr = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    cap_d = (cap_q & ~clr) | edg;
    mask_d = (wr && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
    readdata_d = address == 2'd0 ? 32'(deb_q) :
                 address == 2'd2 ? 32'(mask_q) :
                 address == 2'd3 ? 32'(cap_q) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q <= '{default: '0};
      deb_q <= '0;
      dly_q <= '0;
      mask_q <= '0;
      cap_q <= '0;
      readdata <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
      cnt_q <= cnt_d;
      deb_q <= deb_d;
      dly_q <= deb_q;
      mask_q <= mask_d;
      cap_q <= cap_d;
      readdata <= readdata_d;
    end
  end
endmodule

// File: tb/tb_uart_button_pio.sv
// tb_uart_button_pio: randomized self-checking bench against a pin-history reference model
module tb_uart_button_pio;
  localparam int W = 4;
  localparam int D = 4;
  logic clk = 0;
  logic reset = 1;
  logic [1:0] address = 0;
  logic chipselect = 0;
  logic write_n = 1;
  logic [31:0] writedata = 0;
  logic [31:0] readdata;
  logic [W-1:0] in_port = 0;
  logic irq;
  int total = 0;
  int bad = 0;
  logic [W-1:0] m_p0 = 0, m_p1 = 0, m_deb = 0, m_dly = 0, m_mask = 0, m_cap = 0;
  logic [W-1:0] m_win [D];
  logic [31:0] m_rd = 0;
  uart_button_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic model_step();
    logic [W-1:0] nd, clr;
    bit wr;
    if (reset) begin
      m_p0 = 0; m_p1 = 0; m_deb = 0; m_dly = 0; m_mask = 0; m_cap = 0; m_rd = 0;
      for (int k = 0; k < D; k++) m_win[k] = 0;
    end else begin
      wr = chipselect && !write_n;
      for (int k = 0; k < D - 1; k++) m_win[k] = m_win[k+1];
      m_win[D-1] = m_p1;
      nd = m_deb;
      for (int b = 0; b < W; b++) begin
        bit all_diff = 1;
        for (int k = 0; k < D; k++) if (m_win[k][b] == m_deb[b]) all_diff = 0;
        if (all_diff) nd[b] = ~m_deb[b];
      end
      m_rd = address == 0 ? {28'b0, m_deb} : address == 2 ? {28'b0, m_mask} : address == 3 ? {28'b0, m_cap} : 32'b0;
      clr = (wr && address == 3) ? writedata[W-1:0] : '0;
      m_cap = (m_cap & ~clr) | (m_deb & ~m_dly);
      if (wr && address == 2) m_mask = writedata[W-1:0];
      m_dly = m_deb;
      m_deb = nd;
      m_p1 = m_p0;
      m_p0 = in_port;
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask
  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1; write_n = 0;
    cyc();
    chipselect = 0; write_n = 1;
  endtask
  task automatic rd_reg(input logic [1:0] a);
    address = a;
    cyc();
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask
  task automatic test_reset();
    reset = 1;
    run(3);
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL reset_readdata got=%h want=0", readdata); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
    reset = 0;
  endtask
  task automatic test_press();
    in_port = 4'b0001; address = 0;
    run(10);
    total++; if (readdata !== 32'h1 || readdata !== m_rd) begin bad++; $display("FAIL press_data got=%h want=%h", readdata, m_rd); end
    rd_reg(3);
    total++; if (readdata !== 32'h1 || readdata !== m_rd) begin bad++; $display("FAIL press_cap got=%h want=%h", readdata, m_rd); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL press_irq_masked got=%b want=0", irq); end
  endtask
  task automatic test_irq();
    wr_reg(3, 32'h1);
    wr_reg(2, 32'h1);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_after_clear got=%b want=0", irq); end
    in_port = 4'b0000; run(10);
    in_port = 4'b0001; run(10);
    total++; if (irq !== 1'b1 || irq !== |(m_cap & m_mask)) begin bad++; $display("FAIL irq_on_press got=%b want=1", irq); end
    wr_reg(3, 32'h1);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_w1c got=%b want=0", irq); end
    rd_reg(3);
    total++; if (readdata !== 32'h0 || readdata !== m_rd) begin bad++; $display("FAIL cap_w1c got=%h want=%h", readdata, m_rd); end
  endtask
  task automatic test_glitch();
    in_port = 4'b0000; run(10);
    wr_reg(3, 32'hF);
    in_port = 4'b0100; run(3);
    in_port = 4'b0000; run(10);
    rd_reg(0);
    total++; if (readdata !== 32'h0 || readdata !== m_rd) begin bad++; $display("FAIL glitch_data got=%h want=%h", readdata, m_rd); end
    rd_reg(3);
    total++; if (readdata !== 32'h0 || readdata !== m_rd) begin bad++; $display("FAIL glitch_cap got=%h want=%h", readdata, m_rd); end
  endtask
  task automatic test_reset_mid();
    int first = 0;
    in_port = 4'b1000;
    run(4);
    reset = 1;
    cyc();
    reset = 0;
    total++; if (readdata !== 32'h0 || irq !== 1'b0) begin bad++; $display("FAIL mid_reset_out got=%h/%b want=0/0", readdata, irq); end
    rd_reg(2);
    total++; if (readdata !== 32'h0 || readdata !== m_rd) begin bad++; $display("FAIL mid_reset_mask got=%h want=0", readdata); end
    rd_reg(3);
    total++; if (readdata !== 32'h0 || readdata !== m_rd) begin bad++; $display("FAIL mid_reset_cap got=%h want=0", readdata); end
    address = 0;
    for (int n = 3; n <= 14; n++) begin
      cyc();
      if (first == 0 && readdata[3]) first = n;
    end
    total++; if (first != 7) begin bad++; $display("FAIL mid_reset_accept_cycle got=%0d want=7", first); end
    rd_reg(3);
    total++; if (readdata !== 32'h8 || readdata !== m_rd) begin bad++; $display("FAIL mid_reset_cap_after got=%h want=8", readdata); end
  endtask
  task automatic test_set_wins();
    bit hit = 0;
    wr_reg(3, 32'hF);
    in_port = 4'b1010;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (m_deb[1] && !m_dly[1]) begin
        wr_reg(3, 32'h2);
        hit = 1;
      end else cyc();
    end
    total++; if (!hit) begin bad++; $display("FAIL set_wins_edge got=none want=edge within 20 cycles"); end
    rd_reg(3);
    total++; if (readdata[1] !== 1'b1 || readdata !== m_rd) begin bad++; $display("FAIL set_wins_cap got=%h want=%h", readdata, m_rd); end
  endtask
  task automatic test_regs();
    rd_reg(1);
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL addr1_read got=%h want=0", readdata); end
    wr_reg(1, 32'hFFFFFFFF);
    wr_reg(2, 32'hFFFFFFFF);
    rd_reg(2);
    total++; if (readdata !== 32'h0000000F || readdata !== m_rd) begin bad++; $display("FAIL mask_read got=%h want=0000000f", readdata); end
    wr_reg(0, 32'h0);
    rd_reg(0);
    total++; if (readdata !== 32'hA || readdata !== m_rd) begin bad++; $display("FAIL data_write_ignored got=%h want=0000000a", readdata); end
    rd_reg(1);
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL addr1_after_write got=%h want=0", readdata); end
  endtask
  task automatic test_random();
    logic [W-1:0] p = in_port;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(5) == 0) p = p ^ W'(1 << $urandom_range(W - 1));
      in_port = p;
      address = 2'($urandom_range(3));
      chipselect = 1'($urandom_range(1));
      write_n = 1'($urandom_range(1));
      writedata = $urandom;
      cyc();
      total++; if (readdata !== m_rd) begin bad++; $display("FAIL rand_readdata cyc=%0d got=%h want=%h", i, readdata, m_rd); end
      total++; if (irq !== |(m_cap & m_mask)) begin bad++; $display("FAIL rand_irq cyc=%0d got=%b want=%b", i, irq, |(m_cap & m_mask)); end
    end
    chipselect = 0; write_n = 1;
  endtask
  initial begin
    for (int k = 0; k < D; k++) m_win[k] = 0;
    @(negedge clk);
    test_reset();
    test_press();
    test_irq();
    test_glitch();
    test_reset_mid();
    test_set_wins();
    test_regs();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
